// File: rtl/register_file_sequencer.sv
// Bulk-transfer engine: loads a run of consecutive registers from an input stream,
// or dumps a run onto an output stream, via the register file's write and first read port.
module register_file_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdOp,
  input  logic [ADDR_WIDTH-1:0] cmdStart,
  input  logic [ADDR_WIDTH:0]   cmdCount,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [ADDR_WIDTH-1:0] outIndex,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] readRegisterOne,
  input  logic [DATA_WIDTH-1:0] readDataOne
);

  typedef enum logic [1:0] {StIdle, StLoad, StDump} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    cmdReady    = 1'b0;
    inReady     = 1'b0;
    writeEnable = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmdReady = 1'b1;
        if (cmdValid && cmdCount != '0) begin
          ptr_d       = cmdStart;
          remaining_d = cmdCount;
          state_d     = cmdOp ? StDump : StLoad;
        end
      end
      StLoad: begin
        inReady     = 1'b1;
        writeEnable = inValid;
        if (inValid) begin
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) state_d = StIdle;
        end
      end
      StDump: begin
        // Output register refills whenever it is empty or being drained this cycle.
        if ((!out_valid_q || outReady) && remaining_q != '0) begin
          out_data_d  = readDataOne;
          out_index_d = ptr_q;
          out_valid_d = 1'b1;
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end else if (out_valid_q && outReady) begin
          out_valid_d = 1'b0;
        end
        if (remaining_q == '0 && (!out_valid_q || outReady)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign outValid        = out_valid_q;
  assign outData         = out_data_q;
  assign outIndex        = out_index_q;
  assign busy            = (state_q != StIdle);
  assign writeRegister   = ptr_q;
  assign writeData       = inData;
  assign readRegisterOne = ptr_q;

endmodule

// File: tb/tb_register_file_sequencer.sv
// Directed bench for register_file_sequencer with a register-file model and
// write/dump scoreboards.
module tb_register_file_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdValid, cmdReady, cmdOp;
  logic [4:0]  cmdStart;
  logic [5:0]  cmdCount;
  logic        inValid, inReady;
  logic [31:0] inData;
  logic        outValid, outReady;
  logic [31:0] outData;
  logic [4:0]  outIndex;
  logic        busy;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [4:0]  readRegisterOne;
  logic [31:0] readDataOne;

  register_file_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdStart(cmdStart), .cmdCount(cmdCount),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outIndex(outIndex),
    .busy(busy),
    .writeRegister(writeRegister), .writeData(writeData), .writeEnable(writeEnable),
    .readRegisterOne(readRegisterOne), .readDataOne(readDataOne)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous write, combinational read.
  logic [31:0] rf [0:31];
  always @(posedge clk) if (writeEnable) rf[writeRegister] <= writeData;
  assign readDataOne = rf[readRegisterOne];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } item_t;

  item_t       wr_q[$];
  item_t       out_q[$];
  logic [31:0] shadow [0:31];
  logic [31:0] words[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compares every write and every accepted dump word.
  always @(negedge clk) begin
    item_t e;
    if (rst) begin
      if (writeEnable) begin
        chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("write_index", 32'(writeRegister), 32'(e.idx));
          chk("write_data", writeData, e.data);
        end
      end
      if (outValid && outReady) begin
        chk("dump_expected", 32'(out_q.size() != 0), 32'd1);
        if (out_q.size() != 0) begin
          e = out_q.pop_front();
          chk("dump_index", 32'(outIndex), 32'(e.idx));
          chk("dump_data", outData, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [4:0] start, input logic [5:0] count);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdStart = start;
    cmdCount = count;
    chk("cmd_ready", 32'(cmdReady), 32'd1);
    step();
    cmdValid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] start, input int count, input int n_send,
                         input bit gap);
    logic [4:0] idx;
    for (int i = 0; i < n_send; i++) begin
      idx = start + 5'(i);
      wr_q.push_back('{idx: idx, data: words[i]});
      shadow[idx] = words[i];
    end
    send_cmd(1'b0, start, 6'(count));
    for (int i = 0; i < n_send; i++) begin
      inValid = 1'b1;
      inData  = words[i];
      step();
      chk("load_busy", 32'(busy), 32'(i != count - 1));
      if (gap && i != n_send - 1) begin
        inValid = 1'b0;
        inData  = 32'hDEAD_BEEF;
        step();
        chk("load_gap_busy", 32'(busy), 32'd1);
      end
    end
    inValid = 1'b0;
  endtask

  task automatic do_dump(input logic [4:0] start, input int n, input bit stall, input bit poke);
    int t;
    for (int i = 0; i < n; i++)
      out_q.push_back('{idx: start + 5'(i), data: shadow[start + 5'(i)]});
    outReady = !stall;
    send_cmd(1'b1, start, 6'(n));
    chk("dump_no_early_valid", 32'(outValid), 32'd0);
    if (!stall) begin
      for (int k = 1; k <= n + 1; k++) begin
        if (poke && k == 2) begin
          cmdValid = 1'b1;
          cmdOp    = 1'b0;
          cmdStart = 5'd0;
          cmdCount = 6'd5;
          #1;
          chk("cmd_ignored_busy", 32'(cmdReady), 32'd0);
        end
        step();
        cmdValid = 1'b0;
        if (k == 1) chk("dump_first_valid", 32'(outValid), 32'd1);
        if (k == n) chk("dump_busy_last", 32'(busy), 32'd1);
        if (k == n + 1) begin
          chk("dump_idle", 32'(busy), 32'd0);
          chk("dump_valid_low", 32'(outValid), 32'd0);
        end
      end
    end else begin
      step();
      for (int k = 0; k < 3; k++) begin
        chk("stall_valid", 32'(outValid), 32'd1);
        chk("stall_data", outData, shadow[start]);
        chk("stall_index", 32'(outIndex), 32'(start));
        if (k != 2) step();
      end
      outReady = 1'b1;
      t = 0;
      while (busy && t < 50) begin
        step();
        t++;
      end
      chk("stall_done", 32'(busy), 32'd0);
    end
    chk("dump_all_delivered", 32'(out_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    cmdValid = 1'b0;
    cmdOp    = 1'b0;
    cmdStart = '0;
    cmdCount = '0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b1;
    #3;
    chk("rst_cmd_ready", 32'(cmdReady), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(outValid), 32'd0);
    chk("rst_out_data", outData, 32'd0);
    chk("rst_out_index", 32'(outIndex), 32'd0);
    chk("rst_write_enable", 32'(writeEnable), 32'd0);
    chk("rst_in_ready", 32'(inReady), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Basic load then dump; dump also ignores a command pulsed mid-run.
    words = '{32'h0D15EA5E, 32'hFFFFFFFF, 32'h50D1EB0B};
    do_load(5'd5, 3, 3, 1'b0);
    do_dump(5'd5, 3, 1'b0, 1'b1);

    // Index wrap 31 -> 0.
    words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_load(5'd30, 4, 4, 1'b0);
    do_dump(5'd30, 4, 1'b0, 1'b0);

    // Backpressure on the first dump word.
    do_dump(5'd5, 3, 1'b1, 1'b0);

    // Gaps on the input stream.
    words = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_load(5'd20, 4, 4, 1'b1);
    do_dump(5'd20, 4, 1'b0, 1'b0);

    // Reset after 2 of 4 words.
    words = '{32'hC0FFEE00, 32'hC0FFEE01, 32'hC0FFEE02, 32'hC0FFEE03};
    do_load(5'd10, 4, 2, 1'b0);
    inValid = 1'b1;
    inData  = 32'hBAD0BAD0;
    rst     = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_write_enable", 32'(writeEnable), 32'd0);
    chk("abort_in_ready", 32'(inReady), 32'd0);
    chk("abort_out_valid", 32'(outValid), 32'd0);
    chk("abort_out_data", outData, 32'd0);
    chk("abort_out_index", 32'(outIndex), 32'd0);
    chk("abort_cmd_ready", 32'(cmdReady), 32'd1);
    inValid = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_dump(5'd10, 2, 1'b0, 1'b0);

    // Zero-count command is a no-op.
    send_cmd(1'b0, 5'd3, 6'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    inValid = 1'b1;
    inData  = 32'h12345678;
    step();
    step();
    inValid = 1'b0;
    chk("zero_out_valid", 32'(outValid), 32'd0);
    chk("zero_still_idle", 32'(busy), 32'd0);
    chk("writes_all_seen", 32'(wr_q.size()), 32'd0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
